// File: rtl/mem_responder.sv
// mem_responder: arbitrates dcache (read/write) and icache (read) word requests
// onto a single-ported RAM, holds each cache's wait line until its word has
// transferred, and counts completed transfers per source.
//
// Request/wait handshake: a cache raises its enable(s) and holds address, data
// and enables stable. Its wait line stays 1 until the cycle its word completes.
// In that cycle wait is 0 and, on a read, the load data is valid. The word is
// accepted exactly once, in that cycle. Dropping the enables before completion
// withdraws the request with no completion reported.
module mem_responder #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [31:0] dreads,
  output logic [31:0] dwrites,
  output logic [31:0] ireads,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, next_state;
  logic [3:0] starve_cnt;
  logic       d_req;
  logic       i_starve;
  logic       d_done;
  logic       i_done;

  assign d_req     = dREN | dWEN;
  assign i_starve  = iREN && (starve_cnt >= STARVE_LIM);
  assign fsm_state = state;

  // State register; reset returns to IDLE so enables drop immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Arbitration, RAM drive and wait/load generation.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = 32'd0;
    ramstore   = 32'd0;
    dwait      = 1'b1;
    iwait      = 1'b1;
    dload      = 32'd0;
    iload      = 32'd0;
    d_done     = 1'b0;
    i_done     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !i_starve) next_state = DGRANT;
        else if (iREN)          next_state = IGRANT;
      end
      DGRANT: begin
        if (!d_req) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          // Failed attempt: release the RAM and let arbitration retry it.
          next_state = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait      = 1'b0;
            dload      = ramload;
            d_done     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          next_state = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            i_done     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Completion counters and the icache starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dreads     <= 32'd0;
      dwrites    <= 32'd0;
      ireads     <= 32'd0;
      starve_cnt <= 4'd0;
    end else begin
      if (d_done) begin
        if (dWEN) dwrites <= dwrites + 32'd1;
        else      dreads  <= dreads + 32'd1;
        if (iREN) begin
          if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
        end else begin
          starve_cnt <= 4'd0;
        end
      end
      if (i_done) begin
        ireads     <= ireads + 32'd1;
        starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: the bench plays both caches and the RAM
// and checks wait pulses, RAM drive, load data, counters and arbitration order.
module tb_mem_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dREN = 1'b0, dWEN = 1'b0, iREN = 1'b0;
  logic [31:0] daddr = '0, dstore = '0, iaddr = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        dwait, iwait, ramREN, ramWEN;
  logic [31:0] dload, iload, ramaddr, ramstore, dreads, dwrites, ireads;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int ren_hi   = 0;
  int dwait_lo = 0;
  int iwait_lo = 0;
  int both_lo  = 0;

  mem_responder #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dreads(dreads), .dwrites(dwrites), .ireads(ireads),
    .fsm_state(fsm_state)
  );

  // Clock generation
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge and drive the RAM model.
  task automatic cyc(input logic [1:0] rs, input logic [31:0] ld);
    @(posedge CLK);
    #1;
    ramstate = rs;
    ramload  = ld;
  endtask

  // Let combinational outputs settle, then tally the wait/enable activity.
  task automatic settle();
    #3;
    if (ramREN)  ren_hi++;
    if (!dwait)  dwait_lo++;
    if (!iwait)  iwait_lo++;
    if (!dwait && !iwait) both_lo++;
  endtask

  initial begin : main
    logic [9:0] seq;
    int         ncomp;

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    check("rst_dwait", dwait, 1);
    check("rst_iwait", iwait, 1);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_dload", dload, 0);
    check("rst_iload", iload, 0);
    check("rst_cnt", dreads | dwrites | ireads, 0);
    check("rst_state", fsm_state, 0);
    #4 nRST = 1'b1;

    // dcache read at 0x100, two BUSY cycles then ACCESS
    ren_hi = 0;
    cyc(FREE, 32'd0); dREN = 1'b1; daddr = 32'h100; settle();
    check("rd_idle_ren", ramREN, 0);
    cyc(BUSY, 32'd0); settle();
    check("rd_busy_ren", ramREN, 1);
    check("rd_busy_addr", ramaddr, 32'h100);
    check("rd_busy_dwait", dwait, 1);
    cyc(BUSY, 32'd0); settle();
    check("rd_busy2_dwait", dwait, 1);
    cyc(ACCESS, 32'hDEADBEEF); settle();
    check("rd_acc_dwait", dwait, 0);
    check("rd_acc_dload", dload, 32'hDEADBEEF);
    cyc(FREE, 32'hDEADBEEF); dREN = 1'b0; settle();
    check("rd_after_dwait", dwait, 1);
    check("rd_after_dload", dload, 0);
    check("rd_dreads", dreads, 1);
    check("rd_ren_cycles", ren_hi, 3);

    // dcache write with both enables high: write wins
    cyc(FREE, 32'd0); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5; settle();
    cyc(ACCESS, 32'h0); settle();
    check("wr_ramWEN", ramWEN, 1);
    check("wr_ramREN", ramREN, 0);
    check("wr_ramstore", ramstore, 32'h5);
    check("wr_ramaddr", ramaddr, 32'h3100);
    check("wr_dwait", dwait, 0);
    cyc(FREE, 32'd0); dREN = 1'b0; dWEN = 1'b0; settle();
    check("wr_dwrites", dwrites, 1);
    check("wr_dreads", dreads, 1);

    // Both caches requesting continuously, RAM always ready: D,D,D,D,I repeating
    seq = '0;
    ncomp = 0;
    for (int i = 0; i < 40 && ncomp < 10; i++) begin
      cyc(ACCESS, 32'h1234 + 32'(i));
      if (i == 0) begin
        dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h600;
      end
      settle();
      if (!dwait) begin seq = {seq[8:0], 1'b0}; ncomp++; end
      if (!iwait) begin
        seq = {seq[8:0], 1'b1}; ncomp++;
        check("arb_iload", iload, 32'h1234 + 32'(i));
      end
    end
    check("arb_ncomp", ncomp, 10);
    check("arb_seq", {22'd0, seq}, 32'h021);
    cyc(FREE, 32'd0); dREN = 1'b0; iREN = 1'b0; settle();
    check("arb_ireads", ireads, 2);
    check("arb_dreads", dreads, 9);

    // icache read at 0x40: ERROR first, ACCESS on the retry
    cyc(FREE, 32'd0); iREN = 1'b1; iaddr = 32'h40; settle();
    cyc(ERROR, 32'd0); settle();
    check("err_iwait", iwait, 1);
    cyc(FREE, 32'd0); settle();
    check("err_idle_ren", ramREN, 0);
    check("err_idle_state", fsm_state, 0);
    cyc(ACCESS, 32'hCAFEF00D); settle();
    check("err_retry_iwait", iwait, 0);
    check("err_retry_addr", ramaddr, 32'h40);
    check("err_retry_iload", iload, 32'hCAFEF00D);
    cyc(FREE, 32'd0); iREN = 1'b0; settle();
    check("err_ireads", ireads, 3);

    // dcache withdraws mid-BUSY; pending icache request is granted next
    cyc(FREE, 32'd0); dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h80; settle();
    cyc(BUSY, 32'd0); settle();
    check("wd_ren", ramREN, 1);
    check("wd_addr", ramaddr, 32'h200);
    cyc(BUSY, 32'd0); dREN = 1'b0; settle();
    check("wd_drop_ren", ramREN, 0);
    check("wd_dwait", dwait, 1);
    cyc(BUSY, 32'd0); settle();
    check("wd_idle_state", fsm_state, 0);
    cyc(ACCESS, 32'hABCD0001); settle();
    check("wd_iwait", iwait, 0);
    check("wd_iaddr", ramaddr, 32'h80);
    check("wd_iload", iload, 32'hABCD0001);
    cyc(FREE, 32'd0); iREN = 1'b0; settle();
    check("wd_dreads", dreads, 9);
    check("wd_ireads", ireads, 4);

    // Reset during a BUSY dcache grant, then a clean icache read
    cyc(FREE, 32'd0); dREN = 1'b1; daddr = 32'h300; settle();
    cyc(BUSY, 32'd0); settle();
    check("rs_pre_ren", ramREN, 1);
    #1 nRST = 1'b0;
    #1;
    check("rs_ren", ramREN, 0);
    check("rs_dwait", dwait, 1);
    check("rs_iwait", iwait, 1);
    check("rs_dreads", dreads, 0);
    check("rs_ireads", ireads, 0);
    dREN = 1'b0;
    #2 nRST = 1'b1;
    cyc(FREE, 32'd0); iREN = 1'b1; iaddr = 32'h44; settle();
    cyc(ACCESS, 32'h77); settle();
    check("rs_new_iwait", iwait, 0);
    check("rs_new_iload", iload, 32'h77);
    cyc(FREE, 32'd0); iREN = 1'b0; settle();
    check("rs_new_ireads", ireads, 1);

    // Whole-run pulse accounting
    check("tot_dwait_pulses", dwait_lo, 10);
    check("tot_iwait_pulses", iwait_lo, 5);
    check("tot_both_low", both_lo, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
